switch_debounce: RTL and testbench
==================================

# switch_debounce

Input-conditioning stage for the ZedBoard switch-driven arithmetic datapath. It synchronizes and debounces the eight slide switches and the centre push-button. On each debounced button press, it captures a stable 8-bit operand word and presents it, with a one-cycle valid pulse, to the combinational adder stage downstream. Nibble packing matches the adder: operand A is in OPERANDS[3:0] and operand B is in OPERANDS[7:4].

## Interface
- DEBOUNCE_CYCLES, default 1_000_000 (10 ms at 100 MHz): consecutive cycles a synchronized input must differ from its debounced value before the debounced value changes. Legal range is ≥1.
- clk  input  1  system clock, 100 MHz; every flop is clocked on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- SWITCH  input  8  raw, asynchronous slide-switch levels.
- BTNC  input  1  raw, asynchronous centre push-button level.
- SW_STABLE  output  8  debounced switch levels.
- CHANGED  output  1  one-cycle pulse when any SW_STABLE bit updates.
- OPERANDS  output  8  SW_STABLE value captured at the last button press.
- OPERANDS_VALID  output  1  one-cycle pulse when OPERANDS is loaded.

## Operation
- There are 9 identical input channels: SWITCH[7:0] and BTNC.
- **Per-channel synchronizer:** a 2-flop synchronizer produces `s`, which is the raw input delayed by two edges.
- **Per-channel debounce counter** `cnt`, width $clog2(DEBOUNCE_CYCLES+1). Each edge:
  - if `s` == `stable`: cnt←0;
  - else if cnt == DEBOUNCE_CYCLES−1: stable←s, cnt←0;
  - else: cnt←cnt+1.
- **Bounce handling:** any return of `s` to `stable` before the count completes clears `cnt`. Glitches shorter than DEBOUNCE_CYCLES never reach the output.
- **CHANGED:** registered. High for exactly the one cycle in which any SW_STABLE bit has just taken a new value. Multiple bits updating on the same edge produce a single pulse.
- **Capture FSM**, states IDLE and ARMED (internal `btn_stable` is the BTNC debounced level):
  - IDLE → ARMED on `btn_stable` rising 0→1. On the edge after that rise, OPERANDS←SW_STABLE as visible at that edge, and OPERANDS_VALID←1 for one cycle.
  - ARMED → IDLE when `btn_stable` returns to 0. No capture happens in ARMED, so holding the button gives exactly one capture.
- **Simultaneous events:** if SW_STABLE updates on the same edge the capture occurs, OPERANDS takes the pre-update SW_STABLE value.
- **Reset:** while rst_n = 0 on an edge:
  - all synchronizer flops, counters and `stable` values ← 0;
  - FSM ← IDLE;
  - SW_STABLE = 8'h00, CHANGED = 0, OPERANDS = 8'h00, OPERANDS_VALID = 0.
  - Reset asserted mid-count discards the partial count. A press in progress is lost. Switches held high after reset re-qualify normally (D+2 edges).
- OPERANDS holds its value until the next capture or reset.

## Timing
- **Switch latency:** a raw level that is steady from sampling edge 1 onward appears on SW_STABLE after edge D+2 (D = DEBOUNCE_CYCLES). CHANGED is high in that same cycle.
- **Button-to-capture latency:** if BTNC settles high before edge 1, `btn_stable` rises after edge D+2. OPERANDS and OPERANDS_VALID update after edge D+3.
- **D = 1:** no filtering beyond the synchronizer. Latency is 3 edges.
- **Counter:** never exceeds D−1 and never wraps.
- **Outputs:** all outputs are registered, with no combinational paths from inputs to outputs.

## Structure
- Package `debounce_pkg`:
  - SYNC_STAGES = 2;
  - `capture_state_t` enum {IDLE, ARMED};
  - DEFAULT_DEBOUNCE_CYCLES = 1_000_000.
- Sub-module `debounce_bit` (synchronizer, counter and stable flop, parameterized by DEBOUNCE_CYCLES) is instantiated 9 times via generate.
- The top level holds the CHANGED logic and the capture FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset:** hold rst_n = 0 for 3 edges with SWITCH = 8'hFF. Required: all outputs 0. After release, SW_STABLE = 8'hFF exactly 6 edges later, and CHANGED pulses once.
- **Bounce rejection:** toggle SWITCH[0] 0→1→0 with the high period lasting 3 cycles. Required: SW_STABLE stays 8'h00 and CHANGED is never asserted.
- **Basic capture:** set SWITCH = 8'h35 and let it settle, then hold BTNC high for 20 cycles. Required: OPERANDS = 8'h35 with one OPERANDS_VALID pulse 7 edges after BTNC rises, and no second pulse while BTNC is held.
- **Button bounce:** BTNC chatter (1 cycle high, 1 low, 2 high, 1 low), then steady high. Required: exactly one capture, 7 edges after the final rise.
- **Simultaneous events:** SW_STABLE updates 8'h35→8'h36 on the capture edge. Required: OPERANDS = 8'h35, and SW_STABLE = 8'h36 afterwards.
- **Reset mid-operation:** assert rst_n low 2 cycles into a switch qualification count. Required: outputs return to 0, and after release requalification takes a full 6 edges.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch/button input-conditioning stage.
package debounce_pkg;

  // Depth of the per-channel metastability synchronizer.
  localparam int unsigned SYNC_STAGES = 2;

  // 10 ms at 100 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Capture FSM: IDLE waits for a debounced press, ARMED waits for release.
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } capture_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchronizer, run-length debounce counter and the
// debounced level. update_o flags the cycle in which stable_o is about to
// take a new value, so the parent can register a pulse aligned with it.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic update_o
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;

  assign s        = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;

  // Next-state: shift the synchronizer and count cycles where s disagrees.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update_o = 1'b0;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s;
      cnt_d    = '0;
      update_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would let later statements see already-updated state.
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces eight slide switches and the centre button, and on each
// debounced press captures the stable switch word as the adder operands
// (A in OPERANDS[3:0], B in OPERANDS[7:4]) with a one-cycle valid pulse.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] SWITCH,
  input  logic       BTNC,
  output logic [7:0] SW_STABLE,
  output logic       CHANGED,
  output logic [7:0] OPERANDS,
  output logic       OPERANDS_VALID
);

  logic [8:0]     raw;
  logic [8:0]     stable;
  logic [8:0]     update;
  logic           btn_stable;
  logic           unused_btn_update;

  capture_state_t state_q, state_d;
  logic           changed_q, changed_d;
  logic [7:0]     operands_q, operands_d;
  logic           valid_q, valid_d;

  // Channel 8 is the button; channels 7..0 are the switches.
  assign raw               = {BTNC, SWITCH};
  assign btn_stable        = stable[8];
  assign unused_btn_update = update[8];

  for (genvar i = 0; i < 9; i++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw[i]),
      .stable_o(stable[i]),
      .update_o(update[i])
    );
  end

  // CHANGED tracks switch updates; the FSM captures once per debounced press.
  always_comb begin
    changed_d  = |update[7:0];
    state_d    = state_q;
    operands_d = operands_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_stable) begin
          state_d    = ARMED;
          // Pre-edge switch value, so a same-edge switch update is excluded.
          operands_d = stable[7:0];
          valid_d    = 1'b1;
        end
      end
      ARMED: begin
        if (!btn_stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      changed_q  <= 1'b0;
      operands_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      changed_q  <= changed_d;
      operands_q <= operands_d;
      valid_q    <= valid_d;
    end
  end

  assign SW_STABLE      = stable[7:0];
  assign CHANGED        = changed_q;
  assign OPERANDS       = operands_q;
  assign OPERANDS_VALID = valid_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_CYCLES = 4. A reference model
// describes each channel as "the debounced level flips once the last D
// synchronized samples all disagree with it", and a capture happens on the
// edge after the debounced button rises. Expected outputs per edge go into
// a queue; a negedge monitor pops and compares.
module tb_switch_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] SWITCH;
  logic       BTNC;
  logic [7:0] SW_STABLE;
  logic       CHANGED;
  logic [7:0] OPERANDS;
  logic       OPERANDS_VALID;

  always #5 clk = ~clk;

  switch_debounce #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SWITCH        (SWITCH),
    .BTNC          (BTNC),
    .SW_STABLE     (SW_STABLE),
    .CHANGED       (CHANGED),
    .OPERANDS      (OPERANDS),
    .OPERANDS_VALID(OPERANDS_VALID)
  );

  typedef struct packed {
    logic [7:0] sw;
    logic       chg;
    logic [7:0] ops;
    logic       vld;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         valid_seen = 0;
  int         chg_seen = 0;

  // Reference model state.
  logic [8:0] hist[$];
  logic [8:0] m_stable = '0;
  logic       m_rose = 1'b0;
  logic [7:0] m_ops = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Synchronized sample seen k edges before the current one (k = 0 newest).
  function automatic logic [8:0] s_at(input int k);
    int idx;
    idx = hist.size() - 3 - k;
    return (idx >= 0) ? hist[idx] : 9'h000;
  endfunction

  // Apply current inputs for one edge, predicting the outputs after it.
  task automatic tick();
    exp_t       e;
    logic [8:0] nxt;
    logic [8:0] smp;
    logic       cap;
    bit         all_diff;
    e = '0;
    if (!rst_n) begin
      hist.delete();
      m_stable = '0;
      m_rose   = 1'b0;
      m_ops    = '0;
    end else begin
      hist.push_back({BTNC, SWITCH});
      if (hist.size() > 32) void'(hist.pop_front());
      nxt = m_stable;
      for (int b = 0; b < 9; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) begin
          smp = s_at(k);
          if (smp[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) nxt[b] = ~m_stable[b];
      end
      cap = m_rose;
      if (cap) m_ops = m_stable[7:0];
      e.chg    = |(nxt[7:0] ^ m_stable[7:0]);
      m_rose   = nxt[8] & ~m_stable[8];
      m_stable = nxt;
      e.sw     = m_stable[7:0];
      e.ops    = m_ops;
      e.vld    = cap;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sw_stable", SW_STABLE, mon_e.sw);
      check("changed", CHANGED, mon_e.chg);
      check("operands", OPERANDS, mon_e.ops);
      check("operands_valid", OPERANDS_VALID, mon_e.vld);
      valid_seen += int'(OPERANDS_VALID);
      chg_seen   += int'(CHANGED);
    end
  end

  initial begin
    int v0;
    int c0;
    int r;
    rst_n  = 1'b0;
    SWITCH = 8'hFF;
    BTNC   = 1'b0;

    // Reset with switches high, then requalification after release.
    hold(3);
    check("rst_sw", SW_STABLE, 8'h00);
    check("rst_chg", CHANGED, 1'b0);
    check("rst_ops", OPERANDS, 8'h00);
    check("rst_vld", OPERANDS_VALID, 1'b0);
    rst_n = 1'b1;
    hold(5);
    check("rel_sw_early", SW_STABLE, 8'h00);
    hold(1);
    check("rel_sw_6", SW_STABLE, 8'hFF);
    check("rel_chg_6", CHANGED, 1'b1);
    hold(1);
    check("rel_chg_7", CHANGED, 1'b0);
    SWITCH = 8'h00;
    hold(8);

    // Bounce rejection: 3-cycle high on SWITCH[0].
    c0 = chg_seen;
    SWITCH = 8'h01;
    hold(3);
    SWITCH = 8'h00;
    hold(10);
    check("bounce_sw", SW_STABLE, 8'h00);
    check("bounce_chg_cnt", chg_seen - c0, 0);

    // Basic capture: one pulse 7 edges after the press, none while held.
    SWITCH = 8'h35;
    hold(8);
    v0 = valid_seen;
    BTNC = 1'b1;
    hold(6);
    check("cap_vld_early", OPERANDS_VALID, 1'b0);
    hold(1);
    check("cap_vld_7", OPERANDS_VALID, 1'b1);
    check("cap_ops_7", OPERANDS, 8'h35);
    hold(13);
    BTNC = 1'b0;
    hold(8);
    check("cap_pulses", valid_seen - v0, 1);

    // Button chatter then steady high.
    v0 = valid_seen;
    BTNC = 1'b1; tick();
    BTNC = 1'b0; tick();
    BTNC = 1'b1; hold(2);
    BTNC = 1'b0; tick();
    BTNC = 1'b1;
    hold(6);
    check("chat_vld_early", OPERANDS_VALID, 1'b0);
    hold(1);
    check("chat_vld_7", OPERANDS_VALID, 1'b1);
    hold(10);
    BTNC = 1'b0;
    hold(8);
    check("chat_pulses", valid_seen - v0, 1);

    // Switch update lands on the capture edge.
    BTNC = 1'b1;
    tick();
    SWITCH = 8'h36;
    hold(6);
    check("simul_vld", OPERANDS_VALID, 1'b1);
    check("simul_ops", OPERANDS, 8'h35);
    check("simul_sw", SW_STABLE, 8'h36);
    check("simul_chg", CHANGED, 1'b1);
    hold(10);
    BTNC = 1'b0;
    hold(8);

    // Reset two cycles into a qualification count.
    SWITCH = 8'hC3;
    hold(4);
    rst_n = 1'b0;
    hold(2);
    check("mid_rst_sw", SW_STABLE, 8'h00);
    check("mid_rst_ops", OPERANDS, 8'h00);
    check("mid_rst_chg", CHANGED, 1'b0);
    rst_n = 1'b1;
    hold(5);
    check("mid_req_early", SW_STABLE, 8'h00);
    hold(1);
    check("mid_req_6", SW_STABLE, 8'hC3);
    hold(4);

    // Randomized phase against the model.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        rst_n = 1'b0;
        hold(int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end else if (r < 6) begin
        BTNC = ~BTNC;
      end else if (r < 12) begin
        SWITCH = 8'($urandom);
      end else begin
        SWITCH[$urandom_range(0, 7)] ^= 1'b1;
      end
      hold(int'($urandom_range(1, 8)));
    end

    hold(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
